lc3_mem_access: RTL and testbench
=================================

# lc3_mem_access

Memory-access stage of the LC3 pipeline, directly downstream of execute. It consumes the registered execute outputs (instruction word, effective address, store data, memory-op strobe) and sequences LD/LDR/LDI/ST/STR/STI against a synchronous data memory with 1-cycle read latency. Indirect ops use a two-phase FSM. `busy` stalls upstream stages, and load results go to writeback with their destination register.

## Interface
- DW, 16, data/address width; fixed at 16 for LC3.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  execute's Mem_Control output; a memory op is presented this cycle.
- IR_Exec  in  16  instruction word from execute; opcode is [15:12], destination is [11:9].
- pcout  in  16  effective address computed by execute.
- M_Data  in  16  store data from execute.
- Data_dout  in  16  memory read data; valid the cycle after Data_rd=1.
- Data_addr  out  16  memory address.
- Data_din  out  16  memory write data.
- Data_rd  out  1  memory read strobe.
- Data_wr  out  1  memory write strobe.
- busy  out  1  high when state≠IDLE; upstream holds its registers.
- memout  out  16  load result, registered.
- memout_valid  out  1  one-cycle pulse; memout and mem_dr are valid.
- mem_dr  out  3  destination register for memout.
- store_done  out  1  one-cycle pulse after a write completes.

## Operation
- States: IDLE, IND_RD, IND_WAIT, READ, READ_WAIT, WRITE.
- IDLE accepts when mem_valid=1. It latches addr_q←pcout, data_q←M_Data, op_q←IR_Exec[15:12], dr_q←IR_Exec[11:9]. Next state by opcode:
  - LD 0010 or LDR 0110 → READ.
  - ST 0011 or STR 0111 → WRITE.
  - LDI 1010 or STI 1011 → IND_RD.
  - Any other opcode: ignored, remain IDLE, no strobes.
- IND_RD: Data_rd=1, Data_addr=addr_q → IND_WAIT.
- IND_WAIT: addr_q←Data_dout (pointer). LDI → READ; STI → WRITE.
- READ: Data_rd=1, Data_addr=addr_q → READ_WAIT.
- READ_WAIT: memout←Data_dout, mem_dr←dr_q, memout_valid←1 (next cycle) → IDLE.
- WRITE: Data_wr=1, Data_addr=addr_q, Data_din=data_q; store_done←1 (next cycle) → IDLE.
- Data_rd, Data_wr, Data_addr and Data_din are decoded from the state and registers. In IDLE, all four are 0. Data_rd and Data_wr are never high together.
- mem_valid while busy=1 is ignored. Upstream must hold the op until busy=0, and it is then accepted in that IDLE cycle.
- memout and mem_dr hold their last value until the next load. memout_valid and store_done are single-cycle pulses.

## Timing
- Cycle 0 is the IDLE cycle with mem_valid=1.
- LD/LDR: READ in cycle 1, READ_WAIT in cycle 2, memout_valid in cycle 3. busy is high in cycles 1–2.
- LDI: IND_RD cycle 1, IND_WAIT 2, READ 3, READ_WAIT 4, memout_valid in cycle 5.
- ST/STR: WRITE cycle 1, store_done in cycle 2.
- STI: IND_RD cycle 1, IND_WAIT 2, WRITE 3, store_done in cycle 4.
- Back-to-back: a new op can be accepted in the cycle where memout_valid or store_done is pulsing, since the state is IDLE then.
- Reset values: state IDLE; memout 0; mem_dr 0; memout_valid 0; store_done 0; busy 0; Data_* all 0.
- Reset mid-operation: next cycle is IDLE with no strobes. A pending write is dropped and no valid/done pulse is issued.
- Address wrap: addresses are used as-is (16-bit). Pointer value 16'hFFFF is legal.

## Test plan
- Reset: hold rst=1 for 2 cycles during an LDI. Next cycle busy=0, Data_rd=0, Data_wr=0, memout=0, memout_valid=0.
- LD: mem_valid=1, IR_Exec=16'h2A05 (LD R5), pcout=16'h3010, mem[3010]=16'hBEEF. Data_rd=1 with addr 3010 in cycle 1; memout=BEEF, mem_dr=5, memout_valid=1 in cycle 3.
- LDI: IR_Exec=16'hA400 (LDI R2), pcout=16'h3020, mem[3020]=16'h4000, mem[4000]=16'h1234. Reads at 3020 then 4000; memout=1234, mem_dr=2 in cycle 5; busy high cycles 1–4.
- STI: IR_Exec=16'hB600, pcout=16'h3030, M_Data=16'h00AA, mem[3030]=16'h5000. Data_wr=1, addr 5000, din 00AA in cycle 3; store_done in cycle 4; mem[5000]=00AA.
- Stall/back-to-back: ST presented with mem_valid held high during an LD's busy cycles. ST is accepted only in the IDLE cycle where the LD's memout_valid pulses; exactly one write occurs.
- Non-memory op: mem_valid=1 with IR_Exec=16'h1042 (ADD). State stays IDLE, no strobes, no pulses.

Source files
------------

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: sequences LD/LDR/LDI/ST/STR/STI against a
// synchronous data memory with 1-cycle read latency; indirect ops read a pointer first.
module lc3_mem_access #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [DW-1:0] IR_Exec,
  input  logic [DW-1:0] pcout,
  input  logic [DW-1:0] M_Data,
  input  logic [DW-1:0] Data_dout,
  output logic [DW-1:0] Data_addr,
  output logic [DW-1:0] Data_din,
  output logic          Data_rd,
  output logic          Data_wr,
  output logic          busy,
  output logic [DW-1:0] memout,
  output logic          memout_valid,
  output logic [2:0]    mem_dr,
  output logic          store_done
);

  typedef enum logic [2:0] {IDLE, IND_RD, IND_WAIT, READ, READ_WAIT, WRITE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      dr_q, dr_d;
  logic [DW-1:0]   memout_q, memout_d;
  logic [2:0]      mem_dr_q, mem_dr_d;
  logic            memout_valid_q, memout_valid_d;
  logic            store_done_q, store_done_d;

  logic unused_ir;
  assign unused_ir = ^IR_Exec[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      op_q           <= '0;
      dr_q           <= '0;
      memout_q       <= '0;
      mem_dr_q       <= '0;
      memout_valid_q <= 1'b0;
      store_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      op_q           <= op_d;
      dr_q           <= dr_d;
      memout_q       <= memout_d;
      mem_dr_q       <= mem_dr_d;
      memout_valid_q <= memout_valid_d;
      store_done_q   <= store_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    op_d           = op_q;
    dr_d           = dr_q;
    memout_d       = memout_q;
    mem_dr_d       = mem_dr_q;
    memout_valid_d = 1'b0;
    store_done_d   = 1'b0;
    Data_addr      = '0;
    Data_din       = '0;
    Data_rd        = 1'b0;
    Data_wr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d = pcout;
          data_d = M_Data;
          op_d   = IR_Exec[15:12];
          dr_d   = IR_Exec[11:9];
          case (IR_Exec[15:12])
            4'b0010, 4'b0110: state_d = READ;
            4'b0011, 4'b0111: state_d = WRITE;
            4'b1010, 4'b1011: state_d = IND_RD;
            default:          state_d = IDLE;
          endcase
        end
      end
      IND_RD: begin
        Data_rd   = 1'b1;
        Data_addr = addr_q;
        state_d   = IND_WAIT;
      end
      IND_WAIT: begin
        // Pointer arrives now; it becomes the effective address for the second phase.
        addr_d  = Data_dout;
        state_d = (op_q == 4'b1011) ? WRITE : READ;
      end
      READ: begin
        Data_rd   = 1'b1;
        Data_addr = addr_q;
        state_d   = READ_WAIT;
      end
      READ_WAIT: begin
        memout_d       = Data_dout;
        mem_dr_d       = dr_q;
        memout_valid_d = 1'b1;
        state_d        = IDLE;
      end
      WRITE: begin
        Data_wr      = 1'b1;
        Data_addr    = addr_q;
        Data_din     = data_q;
        store_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign memout       = memout_q;
  assign mem_dr       = mem_dr_q;
  assign memout_valid = memout_valid_q;
  assign store_done   = store_done_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Bench for lc3_mem_access: directed scenarios plus randomized ops against a
// reference memory image and per-opcode timing rules.
module tb_lc3_mem_access;
  logic        clk = 1'b0, rst = 1'b1, mem_valid = 1'b0;
  logic [15:0] IR_Exec = '0, pcout = '0, M_Data = '0, Data_dout;
  logic [15:0] Data_addr, Data_din, memout;
  logic        Data_rd, Data_wr, busy, memout_valid, store_done;
  logic [2:0]  mem_dr;

  lc3_mem_access dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .IR_Exec(IR_Exec), .pcout(pcout),
    .M_Data(M_Data), .Data_dout(Data_dout), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_rd(Data_rd), .Data_wr(Data_wr), .busy(busy), .memout(memout),
    .memout_valid(memout_valid), .mem_dr(mem_dr), .store_done(store_done)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, 1-cycle read latency, plus a backdoor loader.
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] rdata = '0, bd_addr = '0, bd_data = '0;
  logic        clr = 1'b0, bd_we = 1'b0;
  int          wr_cnt = 0;
  assign Data_dout = rdata;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 65536; i++) mem[i] <= '0;
    else if (bd_we) mem[bd_addr] <= bd_data;
    else if (Data_wr) begin
      mem[Data_addr] <= Data_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (Data_rd) rdata <= mem[Data_addr];
  end

  int n_vec = 0, n_err = 0;
  logic [15:0] exp_memout = '0;
  logic [2:0]  exp_dr = '0;

  task poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk); bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task present(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] md);
    mem_valid = 1'b1; IR_Exec = ir; pcout = pc; M_Data = md;
  endtask

  task test_reset;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    rst = 1'b1; clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    n_vec++; if (Data_rd !== 1'b0 || Data_wr !== 1'b0) begin n_err++; $display("FAIL reset_strobes got rd=%0h wr=%0h exp=0", Data_rd, Data_wr); end
    n_vec++; if (Data_addr !== 16'h0 || Data_din !== 16'h0) begin n_err++; $display("FAIL reset_bus got addr=%h din=%h exp=0", Data_addr, Data_din); end
    n_vec++; if (memout !== 16'h0 || mem_dr !== 3'd0) begin n_err++; $display("FAIL reset_memout got=%h dr=%0d exp=0", memout, mem_dr); end
    n_vec++; if (memout_valid !== 1'b0 || store_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses got v=%0h d=%0h exp=0", memout_valid, store_done); end
  endtask

  task test_ld;
    poke(16'h3010, 16'hBEEF);
    present(16'h2A05, 16'h3010, 16'h0);
    @(posedge clk); #1;
    n_vec++; if (Data_rd !== 1'b1 || Data_addr !== 16'h3010 || busy !== 1'b1) begin n_err++; $display("FAIL ld_c1 got rd=%0h addr=%h busy=%0h exp 1/3010/1", Data_rd, Data_addr, busy); end
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1 || memout_valid !== 1'b0 || Data_rd !== 1'b0) begin n_err++; $display("FAIL ld_c2 got busy=%0h v=%0h rd=%0h exp 1/0/0", busy, memout_valid, Data_rd); end
    @(posedge clk); #1;
    n_vec++; if (memout !== 16'hBEEF || mem_dr !== 3'd5 || memout_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ld_c3 got memout=%h dr=%0d v=%0h busy=%0h exp BEEF/5/1/0", memout, mem_dr, memout_valid, busy); end
    @(posedge clk); #1;
    n_vec++; if (memout !== 16'hBEEF || memout_valid !== 1'b0) begin n_err++; $display("FAIL ld_hold got memout=%h v=%0h exp BEEF/0", memout, memout_valid); end
  endtask

  task test_ldi;
    poke(16'h3020, 16'h4000);
    poke(16'h4000, 16'h1234);
    present(16'hA400, 16'h3020, 16'h0);
    @(posedge clk); #1;
    n_vec++; if (Data_rd !== 1'b1 || Data_addr !== 16'h3020 || busy !== 1'b1) begin n_err++; $display("FAIL ldi_c1 got rd=%0h addr=%h busy=%0h exp 1/3020/1", Data_rd, Data_addr, busy); end
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1 || Data_rd !== 1'b0) begin n_err++; $display("FAIL ldi_c2 got busy=%0h rd=%0h exp 1/0", busy, Data_rd); end
    @(posedge clk); #1;
    n_vec++; if (Data_rd !== 1'b1 || Data_addr !== 16'h4000 || busy !== 1'b1) begin n_err++; $display("FAIL ldi_c3 got rd=%0h addr=%h busy=%0h exp 1/4000/1", Data_rd, Data_addr, busy); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1 || memout_valid !== 1'b0) begin n_err++; $display("FAIL ldi_c4 got busy=%0h v=%0h exp 1/0", busy, memout_valid); end
    @(posedge clk); #1;
    n_vec++; if (memout !== 16'h1234 || mem_dr !== 3'd2 || memout_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ldi_c5 got memout=%h dr=%0d v=%0h busy=%0h exp 1234/2/1/0", memout, mem_dr, memout_valid, busy); end
    @(negedge clk);
  endtask

  task test_sti;
    poke(16'h3030, 16'h5000);
    present(16'hB600, 16'h3030, 16'h00AA);
    @(posedge clk); #1;
    n_vec++; if (Data_rd !== 1'b1 || Data_addr !== 16'h3030 || Data_wr !== 1'b0) begin n_err++; $display("FAIL sti_c1 got rd=%0h addr=%h wr=%0h exp 1/3030/0", Data_rd, Data_addr, Data_wr); end
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1 || Data_wr !== 1'b0) begin n_err++; $display("FAIL sti_c2 got busy=%0h wr=%0h exp 1/0", busy, Data_wr); end
    @(posedge clk); #1;
    n_vec++; if (Data_wr !== 1'b1 || Data_rd !== 1'b0 || Data_addr !== 16'h5000 || Data_din !== 16'h00AA) begin n_err++; $display("FAIL sti_c3 got wr=%0h rd=%0h addr=%h din=%h exp 1/0/5000/00AA", Data_wr, Data_rd, Data_addr, Data_din); end
    @(posedge clk); #1;
    n_vec++; if (store_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL sti_c4 got done=%0h busy=%0h exp 1/0", store_done, busy); end
    n_vec++; if (mem[16'h5000] !== 16'h00AA) begin n_err++; $display("FAIL sti_mem got=%h exp=00AA", mem[16'h5000]); end
    ref_mem[16'h5000] = 16'h00AA;
    @(negedge clk);
  endtask

  task test_back_to_back;
    int w0;
    poke(16'h3040, 16'hCAFE);
    w0 = wr_cnt;
    present(16'h2600, 16'h3040, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_vec++; if (Data_wr !== 1'b0) begin n_err++; $display("FAIL b2b_nowr_c%0d got wr=%0h exp=0", k, Data_wr); end
      @(negedge clk);
      if (k == 1) present(16'h3000, 16'h3050, 16'h7777);
    end
    n_vec++; if (memout_valid !== 1'b1 || memout !== 16'hCAFE || mem_dr !== 3'd3) begin n_err++; $display("FAIL b2b_ld got v=%0h memout=%h dr=%0d exp 1/CAFE/3", memout_valid, memout, mem_dr); end
    @(posedge clk); #1;
    n_vec++; if (Data_wr !== 1'b1 || Data_addr !== 16'h3050 || Data_din !== 16'h7777) begin n_err++; $display("FAIL b2b_st got wr=%0h addr=%h din=%h exp 1/3050/7777", Data_wr, Data_addr, Data_din); end
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (store_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%0h exp=1", store_done); end
    @(posedge clk); #1;
    n_vec++; if (wr_cnt - w0 !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_wrcount got=%0d busy=%0h exp 1/0", wr_cnt - w0, busy); end
    ref_mem[16'h3050] = 16'h7777;
    exp_memout = 16'hCAFE; exp_dr = 3'd3;
    @(negedge clk);
  endtask

  task test_nonmem;
    present(16'h1042, 16'h3060, 16'h1111);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0 || Data_rd !== 1'b0 || Data_wr !== 1'b0 || memout_valid !== 1'b0 || store_done !== 1'b0) begin n_err++; $display("FAIL nonmem_c%0d got busy=%0h rd=%0h wr=%0h v=%0h d=%0h exp all 0", k, busy, Data_rd, Data_wr, memout_valid, store_done); end
    end
    @(negedge clk); mem_valid = 1'b0;
  endtask

  task test_reset_mid;
    int w0;
    poke(16'h3070, 16'h6000);
    poke(16'h6000, 16'h1111);
    present(16'hA800, 16'h3070, 16'h0);
    @(posedge clk);
    @(negedge clk); mem_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0 || Data_rd !== 1'b0 || Data_wr !== 1'b0) begin n_err++; $display("FAIL rstmid_state got busy=%0h rd=%0h wr=%0h exp 0", busy, Data_rd, Data_wr); end
    n_vec++; if (memout !== 16'h0 || memout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_memout got=%h v=%0h exp 0/0", memout, memout_valid); end
    exp_memout = '0; exp_dr = '0;
    // STI interrupted after its pointer read: the write must never happen.
    poke(16'h3080, 16'h7000);
    w0 = wr_cnt;
    present(16'hB000, 16'h3080, 16'h5555);
    @(posedge clk);
    @(negedge clk); mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++; if (Data_wr !== 1'b0 || store_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_sti_c%0d got wr=%0h d=%0h busy=%0h exp 0", k, Data_wr, store_done, busy); end
    end
    n_vec++; if (wr_cnt !== w0) begin n_err++; $display("FAIL rstmid_dropped got writes=%0d exp 0", wr_cnt - w0); end
    @(negedge clk);
  endtask

  task test_random;
    logic [3:0]  opc;
    logic [2:0]  dr;
    logic [15:0] pc, md, ea;
    logic        ld, st, ind, e_rd, e_wr;
    int          lat, bad;
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 6))
        0: opc = 4'b0010; 1: opc = 4'b0110; 2: opc = 4'b1010;
        3: opc = 4'b0011; 4: opc = 4'b0111; 5: opc = 4'b1011;
        default: begin
          opc = 4'($urandom);
          while (opc inside {4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011}) opc = 4'($urandom);
        end
      endcase
      dr  = 3'($urandom);
      pc  = $urandom_range(0, 1) ? (16'hFFF8 | 16'($urandom_range(0, 7))) : 16'($urandom);
      md  = ($urandom_range(0, 2) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 7))) : 16'($urandom);
      ld  = opc inside {4'b0010, 4'b0110, 4'b1010};
      st  = opc inside {4'b0011, 4'b0111, 4'b1011};
      ind = opc inside {4'b1010, 4'b1011};
      ea  = ind ? ref_mem[pc] : pc;
      lat = ld ? (ind ? 5 : 3) : (st ? (ind ? 4 : 2) : 1);
      present({opc, dr, 9'($urandom)}, pc, md);
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        e_rd = (k == 1 && (ld || ind)) || (k == 3 && ld && ind);
        e_wr = (k == 1 && st && !ind) || (k == 3 && st && ind);
        if (ld && k == lat) begin exp_memout = ref_mem[ea]; exp_dr = dr; end
        n_vec++; if (Data_rd !== e_rd || Data_wr !== e_wr) begin n_err++; $display("FAIL rnd%0d_strobe op=%h k=%0d got rd=%0h wr=%0h exp %0h/%0h", t, opc, k, Data_rd, Data_wr, e_rd, e_wr); end
        n_vec++; if (busy !== (k < lat)) begin n_err++; $display("FAIL rnd%0d_busy op=%h k=%0d got=%0h exp=%0h", t, opc, k, busy, k < lat); end
        n_vec++; if (memout_valid !== (ld && k == lat) || store_done !== (st && k == lat)) begin n_err++; $display("FAIL rnd%0d_pulse op=%h k=%0d got v=%0h d=%0h", t, opc, k, memout_valid, store_done); end
        n_vec++; if (memout !== exp_memout || mem_dr !== exp_dr) begin n_err++; $display("FAIL rnd%0d_memout op=%h k=%0d got=%h dr=%0d exp=%h dr=%0d", t, opc, k, memout, mem_dr, exp_memout, exp_dr); end
        if (e_rd || e_wr) begin
          n_vec++; if (Data_addr !== ((k == 1) ? pc : ea)) begin n_err++; $display("FAIL rnd%0d_addr op=%h k=%0d got=%h exp=%h", t, opc, k, Data_addr, (k == 1) ? pc : ea); end
        end
        if (e_wr) begin
          n_vec++; if (Data_din !== md) begin n_err++; $display("FAIL rnd%0d_din got=%h exp=%h", t, Data_din, md); end
        end
        if (k == lat) begin
          n_vec++; if (Data_addr !== 16'h0 || Data_din !== 16'h0) begin n_err++; $display("FAIL rnd%0d_idlebus got addr=%h din=%h exp 0", t, Data_addr, Data_din); end
        end
        @(negedge clk);
        // While busy, dangle unrelated requests that must be ignored.
        if (k == 1) begin mem_valid = 1'($urandom); IR_Exec = 16'($urandom); pcout = 16'($urandom); end
      end
      if (st) ref_mem[ea] = md;
    end
    mem_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rnd_mem_image got %0d differing words exp 0", bad); end
  endtask

  initial begin
    test_reset;
    test_ld;
    test_ldi;
    test_sti;
    test_back_to_back;
    test_nonmem;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
